// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller and the instruction decoder:
// state encodings, opcodes and datapath mux/ALU field values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;
  localparam logic [1:0] ALUB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that wait on the memory handshake and are bounded by the wait counter
  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_waitcnt.sv
// Memory wait counter: counts stalled cycles in a memory state and flags
// when the count has reached TIMEOUT.
module mc_waitcnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [7:0] TMAX = 8'(TIMEOUT);

  logic [7:0] cnt;

  // clr wins over inc so an aborted access re-enters its state from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  end

  assign hit = (cnt == TMAX);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: Moore output decode per state, with FETCH
// write enables qualified by mem_ready and a bounded memory wait.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state_o
);

  state_t state, state_n;
  logic   hit, inc, timeout, clr;

  assign inc     = is_wait(state) && !mem_ready;
  assign timeout = inc && hit;
  assign clr     = (state_n != state) || timeout;

  mc_waitcnt #(.TIMEOUT(TIMEOUT)) u_waitcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .hit   (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      mem_timeout <= timeout;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:   if (mem_ready) state_n = S_DECODE;
                 else if (hit)  state_n = S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_n = S_EXECUTE;
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_BEQ:       state_n = S_BRANCH;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR:  state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_n = S_MEMWB;
                 else if (hit)  state_n = S_FETCH;
      S_MEMWB:   state_n = S_FETCH;
      S_MEMWR:   if (mem_ready || hit) state_n = S_FETCH;
      S_EXECUTE: state_n = S_ALUWB;
      S_ALUWB:   state_n = S_FETCH;
      S_BRANCH:  state_n = S_FETCH;
      S_ADDIEX:  state_n = S_ADDIWB;
      S_ADDIWB:  state_n = S_FETCH;
      S_JUMP:    state_n = S_FETCH;
      default:   state_n = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    illegal_op = 1'b0;
    alusrcb    = ALUB_REG;
    pcsrc      = PC_ALU;
    aluop      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = ALUB_FOUR;
        // reset held high must not let a stray mem_ready write IR/PC
        irwrite = mem_ready && !reset;
        pcwrite = mem_ready && !reset;
      end
      S_DECODE: begin
        alusrcb    = ALUB_BOFF;
        illegal_op = (op != OP_RTYPE) && (op != OP_LW) && (op != OP_SW) &&
                     (op != OP_BEQ) && (op != OP_ADDI) && (op != OP_J);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
